// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: state encoding and oversampling points.
package uart_rx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_STOP  = 3'd3;
    localparam state_t ST_BREAK = 3'd4;

    localparam int unsigned OVERSAMPLE_DEF = 16;

    // Majority-vote sample points for the default 16x oversampling
    localparam int unsigned SAMPLE_EARLY = 7;
    localparam int unsigned SAMPLE_MID   = 8;
    localparam int unsigned SAMPLE_LATE  = 9;

    // Re-centres a default sample point on OVERSAMPLE/2 for other oversampling ratios
    function automatic int unsigned scale_pt(input int unsigned pt, input int unsigned os);
        return pt + os / 2 - OVERSAMPLE_DEF / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous level input; resets to 1 (idle-high lines).
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rx, start detection, 3-sample majority vote per bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       brg16_tick,
    input  logic       rx,
    output logic [7:0] d,
    output logic       rx_done_tick,
    output logic       rx_ferr_tick,
    output logic       rx_busy
);

    localparam int unsigned CTR_W = $clog2(OVERSAMPLE);
    localparam logic [CTR_W-1:0] C_EARLY = CTR_W'(scale_pt(SAMPLE_EARLY, OVERSAMPLE));
    localparam logic [CTR_W-1:0] C_MID   = CTR_W'(scale_pt(SAMPLE_MID, OVERSAMPLE));
    localparam logic [CTR_W-1:0] C_LATE  = CTR_W'(scale_pt(SAMPLE_LATE, OVERSAMPLE));
    localparam logic [CTR_W-1:0] C_LAST  = CTR_W'(OVERSAMPLE - 1);

    state_t           r_state;
    logic [CTR_W-1:0] r_ctr;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_d;
    logic             r_s_early;
    logic             r_s_mid;
    logic             r_done;
    logic             r_ferr;
    logic             w_rx_s;
    logic             w_vote;
    logic [CTR_W-1:0] w_ctr_next;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    // The third sample is the live synchronised value on the deciding tick
    assign w_vote     = (r_s_early & r_s_mid) | (r_s_early & w_rx_s) | (r_s_mid & w_rx_s);
    assign w_ctr_next = (r_ctr == C_LAST) ? '0 : r_ctr + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ctr     <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_d       <= '0;
            r_s_early <= 1'b1;
            r_s_mid   <= 1'b1;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_ctr   <= '0;
                    end
                end
                ST_START, ST_DATA, ST_STOP: begin
                    if (brg16_tick) begin
                        r_ctr <= w_ctr_next;
                        if (r_ctr == C_EARLY) r_s_early <= w_rx_s;
                        if (r_ctr == C_MID)   r_s_mid   <= w_rx_s;
                        if (r_ctr == C_LATE) begin
                            if (r_state == ST_START) begin
                                if (w_vote) r_state <= ST_IDLE;
                            end else if (r_state == ST_DATA) begin
                                r_shift <= {w_vote, r_shift[7:1]};
                            end else begin
                                // Stop bit judged mid-bit so the next start edge is never missed
                                r_d <= r_shift;
                                if (w_vote) begin
                                    r_done  <= 1'b1;
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_ferr  <= 1'b1;
                                    r_state <= ST_BREAK;
                                end
                            end
                        end
                        if (r_ctr == C_LAST) begin
                            if (r_state == ST_START) begin
                                r_state  <= ST_DATA;
                                r_bitcnt <= '0;
                            end else if (r_state == ST_DATA) begin
                                if (r_bitcnt == 3'd7) r_state <= ST_STOP;
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign d            = r_d;
    assign rx_done_tick = r_done;
    assign rx_ferr_tick = r_ferr;
    assign rx_busy      = (r_state != ST_IDLE);

endmodule
